// File: rtl/diff_demo_pkg.sv
// Shared types for the instruction dispatcher: instruction layout, FSM states, AXI response codes
// and the default DMA register map.
package diff_demo_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, WR_A, B_A, WR_L, B_L, WAIT_DONE, ERR
  } dispatch_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int DEF_CH_STRIDE = 'h30;
  localparam int DEF_ADDR_OFS  = 'h18;
  localparam int DEF_LEN_OFS   = 'h28;

  // Low 64 bits of an instruction; only the bottom CH_W bits of ch select the channel, the rest are reserved.
  typedef struct packed {
    logic [31:0] addr;
    logic [23:0] len;
    logic [7:0]  ch;
  } ins_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data (dout valid the cycle after rd_en).
// Writes into a full FIFO and reads from an empty one are ignored.
module fifo_sync #(
  parameter int DATA_WIDE = 8,
  parameter int FIFO_DEPT = 16,
  localparam int AW = $clog2(FIFO_DEPT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_WIDE-1:0] din,
  input  logic                 rd_en,
  output logic [DATA_WIDE-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level
);

  logic [DATA_WIDE-1:0] mem [FIFO_DEPT];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(FIFO_DEPT));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/demo_ins_dispatch.sv
// Dispatches buffered DMA instructions as two AXI-Lite writes (address, length) per channel,
// waits for the channel's completion pulse and raises IRQ_REQ at batch end or on a bus error.
module demo_ins_dispatch
  import diff_demo_pkg::*;
#(
  parameter int INS_WIDTH      = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int NUM_CH         = 2,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CH_STRIDE      = DEF_CH_STRIDE,
  parameter int ADDR_OFS       = DEF_ADDR_OFS,
  parameter int LEN_OFS        = DEF_LEN_OFS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INS_WIDTH-1:0]          s_axis_ins_tdata,
  input  logic                          s_axis_ins_tvalid,
  output logic                          s_axis_ins_tready,
  input  logic                          s_axis_ins_tlast,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
  output logic                          m_axi_lite_awvalid,
  input  logic                          m_axi_lite_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_lite_wdata,
  output logic                          m_axi_lite_wvalid,
  input  logic                          m_axi_lite_wready,
  input  logic [1:0]                    m_axi_lite_bresp,
  input  logic                          m_axi_lite_bvalid,
  output logic                          m_axi_lite_bready,
  input  logic [NUM_CH-1:0]             ch_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err,
  input  logic                          IRQ_ACK,
  output logic                          IRQ_REQ
);

  dispatch_state_e state, state_nxt;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [INS_WIDTH:0] fifo_dout;
  ins_t              ld_ins;
  logic              ld_last, ld_skip;
  logic [CH_W-1:0]   ld_ch;

  logic [31:0]       addr_q;
  logic [23:0]       len_q;
  logic [CH_W-1:0]   ch_q;
  logic              last_q, done_pend, irq_q, err_q;
  logic              awvalid_q, wvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;

  logic start_a, start_l, set_err, irq_set, aw_done, w_done, ch_hit, b_ok;

  function automatic logic [AXI_ADDR_WIDTH-1:0] reg_addr(input logic [CH_W-1:0] ch, input int ofs);
    return AXI_ADDR_WIDTH'(ch) * AXI_ADDR_WIDTH'(CH_STRIDE) + AXI_ADDR_WIDTH'(ofs);
  endfunction

  fifo_sync #(
    .DATA_WIDE (INS_WIDTH + 1),
    .FIFO_DEPT (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (s_axis_ins_tvalid),
    .din   ({s_axis_ins_tlast, s_axis_ins_tdata}),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Decode straight from the FIFO read register while in LOAD.
  assign ld_ins  = ins_t'(fifo_dout[63:0]);
  assign ld_last = fifo_dout[INS_WIDTH];
  assign ld_ch   = ld_ins.ch[CH_W-1:0];
  assign ld_skip = (int'(ld_ch) >= NUM_CH) || (ld_ins.len == '0);

  assign aw_done = !awvalid_q || m_axi_lite_awready;
  assign w_done  = !wvalid_q  || m_axi_lite_wready;
  assign ch_hit  = |(ch_done & (NUM_CH'(1) << ch_q));
  assign b_ok    = (m_axi_lite_bresp == AXI_RESP_OKAY);

  assign s_axis_ins_tready  = !fifo_full;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_awaddr  = awaddr_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_bready  = (state == B_A) || (state == B_L);
  assign busy               = (state != IDLE) || !fifo_empty;
  assign err                = err_q;
  assign IRQ_REQ            = irq_q;

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    start_a   = 1'b0;
    start_l   = 1'b0;
    set_err   = 1'b0;
    irq_set   = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: if (ld_skip) begin
        irq_set   = ld_last;
        state_nxt = IDLE;
      end else begin
        start_a   = 1'b1;
        state_nxt = WR_A;
      end
      WR_A: if (aw_done && w_done) state_nxt = B_A;
      B_A: if (m_axi_lite_bvalid) begin
        if (b_ok) begin
          start_l   = 1'b1;
          state_nxt = WR_L;
        end else begin
          set_err   = 1'b1;
          irq_set   = 1'b1;
          state_nxt = ERR;
        end
      end
      WR_L: if (aw_done && w_done) state_nxt = B_L;
      B_L: if (m_axi_lite_bvalid) begin
        if (b_ok) begin
          state_nxt = WAIT_DONE;
        end else begin
          set_err   = 1'b1;
          irq_set   = 1'b1;
          state_nxt = ERR;
        end
      end
      WAIT_DONE: if (ch_hit || done_pend) begin
        irq_set   = last_q;
        state_nxt = IDLE;
      end
      ERR: if (IRQ_ACK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      ch_q      <= '0;
      last_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      done_pend <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        addr_q <= ld_ins.addr;
        len_q  <= ld_ins.len;
        ch_q   <= ld_ch;
        last_q <= ld_last;
      end
      if (start_a || start_l) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= start_a ? reg_addr(ld_ch, ADDR_OFS) : reg_addr(ch_q, LEN_OFS);
        wdata_q   <= start_a ? AXI_DATA_WIDTH'(ld_ins.addr) : AXI_DATA_WIDTH'(len_q);
      end else begin
        if (m_axi_lite_awready) awvalid_q <= 1'b0;
        if (m_axi_lite_wready)  wvalid_q  <= 1'b0;
      end
      // A completion pulse coinciding with the length-write response is held for WAIT_DONE.
      done_pend <= (state == B_L) && m_axi_lite_bvalid && ch_hit;
      if (set_err) err_q <= 1'b1;
      if (irq_set)      irq_q <= 1'b1;
      else if (IRQ_ACK) irq_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demo_ins_dispatch.sv
// Directed + randomized bench for demo_ins_dispatch with an AXI-Lite slave/DMA responder and a
// transaction-level model of the expected register writes.
module tb_demo_ins_dispatch;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam logic [31:0] STRIDE = 32'h30;
  localparam logic [31:0] AOFS   = 32'h18;
  localparam logic [31:0] LOFS   = 32'h28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_ins_tdata;
  logic        s_axis_ins_tvalid, s_axis_ins_tready, s_axis_ins_tlast;
  logic [31:0] m_axi_lite_awaddr, m_axi_lite_wdata;
  logic        m_axi_lite_awvalid, m_axi_lite_awready, m_axi_lite_wvalid, m_axi_lite_wready;
  logic [1:0]  m_axi_lite_bresp;
  logic        m_axi_lite_bvalid, m_axi_lite_bready;
  logic [NUM_CH-1:0] ch_done;
  logic        busy, err, IRQ_ACK, IRQ_REQ;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  demo_ins_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_ins_tdata(s_axis_ins_tdata), .s_axis_ins_tvalid(s_axis_ins_tvalid),
    .s_axis_ins_tready(s_axis_ins_tready), .s_axis_ins_tlast(s_axis_ins_tlast),
    .m_axi_lite_awaddr(m_axi_lite_awaddr), .m_axi_lite_awvalid(m_axi_lite_awvalid),
    .m_axi_lite_awready(m_axi_lite_awready), .m_axi_lite_wdata(m_axi_lite_wdata),
    .m_axi_lite_wvalid(m_axi_lite_wvalid), .m_axi_lite_wready(m_axi_lite_wready),
    .m_axi_lite_bresp(m_axi_lite_bresp), .m_axi_lite_bvalid(m_axi_lite_bvalid),
    .m_axi_lite_bready(m_axi_lite_bready), .ch_done(ch_done), .busy(busy),
    .fifo_level(fifo_level), .err(err), .IRQ_ACK(IRQ_ACK), .IRQ_REQ(IRQ_REQ)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr[$], exp_data[$], obs_addr[$], obs_data[$];
  int cmp_idx = 0;
  bit auto_dma = 0, aw_hold = 0, rand_rdy = 0;
  int w_lag = 0, bad_resp_at = -1;
  int stray_req = 0, stray_ack = 0;
  logic [NUM_CH-1:0] stray_mask = '0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_issued = 0;

  // AXI-Lite slave plus DMA completion model; runs just after each rising edge.
  initial begin : axi_slave
    logic [31:0] aw_fifo[$], w_fifo[$], b_addr_q[$];
    logic [31:0] aw_s, w_s, cur_b_addr;
    bit aw_will, w_will, b_will, dma_pend;
    int dma_wait, dma_ch, w_seen;
    aw_will = 0; w_will = 0; b_will = 0; dma_pend = 0; dma_wait = 0; dma_ch = 0; w_seen = 0;
    aw_s = '0; w_s = '0; cur_b_addr = '0;
    m_axi_lite_awready = 0; m_axi_lite_wready = 0; m_axi_lite_bvalid = 0;
    m_axi_lite_bresp = 2'b00; ch_done = '0;
    forever begin
      @(posedge clk); #1;
      if (aw_will) begin aw_fifo.push_back(aw_s); aw_cnt++; end
      if (w_will) begin w_fifo.push_back(w_s); w_cnt++; w_seen = 0; end
      if (b_will) begin
        b_cnt++;
        if (m_axi_lite_bresp == 2'b00 && auto_dma && (cur_b_addr % STRIDE) == LOFS) begin
          dma_pend = 1; dma_wait = $urandom_range(0, 3); dma_ch = int'(cur_b_addr / STRIDE);
        end
        m_axi_lite_bvalid = 0;
      end
      while (aw_fifo.size() > 0 && w_fifo.size() > 0) begin
        obs_addr.push_back(aw_fifo[0]);
        obs_data.push_back(w_fifo.pop_front());
        b_addr_q.push_back(aw_fifo.pop_front());
      end
      ch_done = '0;
      if (dma_pend) begin
        if (dma_wait == 0) begin ch_done[dma_ch] = 1'b1; dma_pend = 0; end
        else dma_wait--;
      end
      if (stray_req != stray_ack) begin ch_done = ch_done | stray_mask; stray_ack = stray_req; end
      if (!m_axi_lite_bvalid && b_addr_q.size() > 0) begin
        cur_b_addr = b_addr_q.pop_front();
        m_axi_lite_bvalid = 1;
        m_axi_lite_bresp = (b_issued == bad_resp_at) ? 2'b10 : 2'b00;
        b_issued++;
      end
      m_axi_lite_awready = !aw_hold && (!rand_rdy || $urandom_range(0, 1) == 1);
      m_axi_lite_wready  = (w_seen >= w_lag) && (!rand_rdy || $urandom_range(0, 1) == 1);
      if (m_axi_lite_wvalid && !m_axi_lite_wready) w_seen++;
      aw_will = m_axi_lite_awvalid && m_axi_lite_awready; aw_s = m_axi_lite_awaddr;
      w_will  = m_axi_lite_wvalid && m_axi_lite_wready;   w_s  = m_axi_lite_wdata;
      b_will  = m_axi_lite_bvalid && m_axi_lite_bready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each instruction to a real channel with nonzero length yields an address write then a length write.
  function automatic void model_add(input logic [31:0] a, input logic [23:0] l, input logic [7:0] sel);
    int ch;
    ch = int'(sel) % (1 << CH_W);
    if (ch < NUM_CH && l != 0) begin
      exp_addr.push_back(32'(ch) * STRIDE + AOFS); exp_data.push_back(a);
      exp_addr.push_back(32'(ch) * STRIDE + LOFS); exp_data.push_back({8'h00, l});
    end
  endfunction

  task automatic push(input logic [31:0] a, input logic [23:0] l, input logic [7:0] sel, input logic last);
    int n = 0;
    s_axis_ins_tdata = {a, l, sel}; s_axis_ins_tlast = last; s_axis_ins_tvalid = 1;
    while (!s_axis_ins_tready && n < 500) begin @(negedge clk); n++; end
    check("push_ready", s_axis_ins_tready, 1);
    @(negedge clk);
    s_axis_ins_tvalid = 0; s_axis_ins_tlast = 0;
    model_add(a, l, sel);
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_count"}, obs_addr.size(), exp_addr.size());
    while (cmp_idx < obs_addr.size() && cmp_idx < exp_addr.size()) begin
      check({tag, "_addr"}, obs_addr[cmp_idx], exp_addr[cmp_idx]);
      check({tag, "_data"}, obs_data[cmp_idx], exp_data[cmp_idx]);
      cmp_idx++;
    end
  endtask

  task automatic wait_b(input string tag, input int n);
    int k = 0;
    while (b_cnt < n && k < 1000) begin @(negedge clk); k++; end
    check(tag, b_cnt >= n, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check(tag, busy, 0);
  endtask

  task automatic stray(input logic [NUM_CH-1:0] m);
    stray_mask = m; stray_req++;
  endtask

  task automatic ack_irq(input string tag);
    IRQ_ACK = 1; @(negedge clk); IRQ_ACK = 0;
    check(tag, IRQ_REQ, 0);
  endtask

  initial begin
    int base, k;
    bit found, any_last;
    logic [31:0] ra;
    logic [23:0] rl;
    logic rlast;
    rst_n = 0; IRQ_ACK = 0;
    s_axis_ins_tdata = '0; s_axis_ins_tvalid = 0; s_axis_ins_tlast = 0;
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_ins_tready, 1);
    check("rst_awvalid", m_axi_lite_awvalid, 0);
    check("rst_wvalid", m_axi_lite_wvalid, 0);
    check("rst_bready", m_axi_lite_bready, 0);
    check("rst_irq", IRQ_REQ, 0);
    check("rst_err", err, 0);
    check("rst_level", fifo_level, 0);
    check("rst_awaddr", m_axi_lite_awaddr, 0);
    check("rst_wdata", m_axi_lite_wdata, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);

    // Single instruction, completion driven by hand
    push(32'h1000_0000, 24'h400, 8'h00, 1);
    wait_b("t1_bresp", 2);
    cmp_writes("t1");
    repeat (2) @(negedge clk);
    check("t1_irq_wait", IRQ_REQ, 0);
    stray(2'b01);
    @(negedge clk);
    check("t1_irq_pre", IRQ_REQ, 0);
    @(negedge clk);
    check("t1_irq_set", IRQ_REQ, 1);
    ack_irq("t1_ack");

    // Two-instruction batch with a stray pulse on the other channel
    base = obs_addr.size();
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h00, 0);
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h01, 1);
    wait_b("t2_bresp_a", b_cnt + 2);
    repeat (2) @(negedge clk);
    stray(2'b10);
    repeat (4) @(negedge clk);
    check("t2_stray_writes", obs_addr.size(), base + 2);
    check("t2_stray_irq", IRQ_REQ, 0);
    stray(2'b01);
    wait_b("t2_bresp_b", b_cnt + 2);
    cmp_writes("t2");
    repeat (2) @(negedge clk);
    check("t2_irq_wait", IRQ_REQ, 0);
    stray(2'b10);
    @(negedge clk);
    check("t2_irq_pre", IRQ_REQ, 0);
    @(negedge clk);
    check("t2_irq_set", IRQ_REQ, 1);
    ack_irq("t2_ack");

    // awready three cycles ahead of wready
    auto_dma = 1; w_lag = 3;
    base = obs_addr.size();
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h01, 1);
    k = 0;
    while (!m_axi_lite_awvalid && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (m_axi_lite_awvalid && k < 50) begin @(negedge clk); k++; end
    check("t3_aw_dropped", m_axi_lite_awvalid, 0);
    check("t3_w_held", m_axi_lite_wvalid, 1);
    wait_idle("t3_idle", 300);
    check("t3_one_write_per_reg", obs_addr.size(), base + 2);
    check("t3_aw_w_balance", aw_cnt, w_cnt);
    cmp_writes("t3");
    ack_irq("t3_ack");
    w_lag = 0;

    // Bus error on the length write, more input accepted while halted
    base = obs_addr.size();
    bad_resp_at = b_issued + 1;
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h00, 0);
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h01, 1);
    k = 0;
    while (!err && k < 200) begin @(negedge clk); k++; end
    check("t4_err", err, 1);
    check("t4_irq", IRQ_REQ, 1);
    repeat (5) @(negedge clk);
    check("t4_halted_writes", obs_addr.size(), base + 2);
    check("t4_halted_busy", busy, 1);
    check("t4_level", fifo_level, 1);
    push($urandom, 24'($urandom_range(1, 'hffffff)), 8'h00, 0);
    check("t4_level_in_err", fifo_level, 2);
    ack_irq("t4_ack");
    wait_idle("t4_idle", 500);
    cmp_writes("t4");
    check("t4_irq_after", IRQ_REQ, 1);
    check("t4_err_sticky", err, 1);
    ack_irq("t4_ack2");
    bad_resp_at = -1;

    // Fill the FIFO while the address channel is stalled
    aw_hold = 1;
    for (int i = 0; i < 17; i++)
      push($urandom, 24'($urandom_range(1, 'hffffff)), 8'($urandom_range(0, 1)), i == 16);
    check("t5_tready_full", s_axis_ins_tready, 0);
    check("t5_level_full", fifo_level, 16);
    aw_hold = 0;
    wait_idle("t5_idle", 3000);
    cmp_writes("t5");
    check("t5_irq", IRQ_REQ, 1);
    ack_irq("t5_ack");

    // Zero-length skip with IRQ_ACK held across the set cycle
    base = obs_addr.size();
    push($urandom, 24'h0, 8'h00, 1);
    IRQ_ACK = 1;
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk);
      found = IRQ_REQ;
    end
    IRQ_ACK = 0;
    check("t6_irq_within3", found, 1);
    @(negedge clk);
    check("t6_irq_kept", IRQ_REQ, 1);
    check("t6_no_writes", obs_addr.size(), base);
    ack_irq("t6_ack");

    // Randomized traffic with random ready stalls and reserved bits
    rand_rdy = 1; any_last = 0;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rl = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      rlast = ($urandom_range(0, 3) == 0);
      any_last = any_last | rlast;
      push(ra, rl, 8'($urandom_range(0, 255)), rlast);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("t7_idle", 5000);
    cmp_writes("t7");
    check("t7_irq", IRQ_REQ, any_last);
    check("t7_aw_w_balance", aw_cnt, w_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
